instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage of the SOIN-RV core.
- Generates sequential PCs and issues in-order 32-bit reads to instruction memory.
- Buffers returned words in a small prefetch FIFO and presents {PC, instruction} to decode (decoder and immediate generator) over a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing the FIFO and discarding in-flight responses.

Parameters:
- FIFO_DEPTH, 2, prefetch FIFO entries; also the cap on (FIFO occupancy + outstanding requests); power of two, >= 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- i_Clk  input  1  core clock.
- i_Rst  input  1  reset; synchronous, active-high.
- o_IMemReq  output  1  read request valid.
- o_IMemAddr  output  32  read address, word aligned.
- i_IMemGnt  input  1  request accepted this cycle.
- i_IMemRValid  input  1  read data valid; responses return in order, 1 per cycle max.
- i_IMemRData  input  32  read data.
- i_Redirect  input  1  redirect fetch (taken branch, JAL, JALR).
- i_RedirectPc  input  32  redirect target.
- o_InstrValid  output  1  instruction available to decode.
- o_Instruction  output  32  instruction word.
- o_InstrPc  output  32  PC of o_Instruction.
- i_InstrReady  input  1  decode accepts this cycle.
- o_FetchFault  output  1  misaligned redirect fault (macro only; tied 0 otherwise).

Behaviour:
- Reset (i_Rst sampled high at posedge):
  - FetchPc = RespPc = RESET_PC; FIFO empty; Outstanding = 0; DropCnt = 0; state FETCH.
  - o_IMemReq = 0, o_InstrValid = 0, o_FetchFault = 0, o_Instruction = 0, o_InstrPc = 0.
  - Reset mid-transaction abandons everything; responses arriving after reset with Outstanding = 0 are ignored.
- States:
  - FETCH: normal operation.
  - FAULT: exists only with the macro.
- Request rule:
  - o_IMemReq = (state == FETCH) && (FifoCount + Outstanding < FIFO_DEPTH); o_IMemAddr = FetchPc.
  - Once raised, request and address stay stable until i_IMemGnt, except on redirect.
  - On Req && Gnt: FetchPc += 4 (wraps modulo 2^32); Outstanding += 1.
- Response rule, on i_IMemRValid:
  - Outstanding -= 1.
  - If DropCnt > 0: DropCnt -= 1 and the word is discarded.
  - Else: push {RespPc, i_IMemRData} into the FIFO; RespPc += 4.
  - Gnt and RValid in the same cycle: net Outstanding unchanged.
- Output:
  - o_InstrValid = FIFO not empty; o_Instruction/o_InstrPc driven from the FIFO head.
  - Pop on o_InstrValid && i_InstrReady.
  - Push and pop in the same cycle are allowed, including at full and at empty (a word pushed into an empty FIFO is visible the next cycle).
  - Minimum latency: Gnt at cycle N, RValid at N+1, o_InstrValid at N+2.
- Redirect (i_Redirect high), highest priority:
  - Next cycle: FIFO empty; FetchPc = RespPc = i_RedirectPc.
  - DropCnt = Outstanding_next, counting a Gnt in the redirect cycle and excluding an RValid in the redirect cycle; that RValid word is discarded.
  - A pop in the redirect cycle still completes for decode; the FIFO is cleared regardless.
  - o_IMemReq may drop in the cycle after a redirect without a grant.
  - New requests may issue immediately; the credit rule still counts dropped-pending responses.
- Widths:
  - Outstanding and DropCnt are $clog2(FIFO_DEPTH+1) bits and never exceed FIFO_DEPTH.
  - An RValid with Outstanding = 0 is a protocol error and is ignored.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined: a redirect with i_RedirectPc[1:0] != 0 flushes as normal, then enters FAULT.
  - In FAULT: o_FetchFault = 1, o_IMemReq = 0; in-flight responses are dropped.
  - Exit only via an aligned redirect (back to FETCH, fault cleared the next cycle) or reset.
  - A misaligned redirect while already in FAULT keeps FAULT.
- Undefined: i_RedirectPc[1:0] is ignored (forced to 00); there is no FAULT state, and o_FetchFault is tied 0.

Test Plan:
- Reset, zero-wait memory (Gnt always 1, RValid 1 cycle later), ready=1: o_InstrPc sequence 0x0, 0x4, 0x8…; first o_InstrValid 3 cycles after reset release; 1 instruction/cycle sustained.
- Backpressure with ready=0 for 10 cycles, FIFO_DEPTH=2: exactly 2 grants issued, then o_IMemReq=0; on ready=1 words drain in order with no loss or duplication.
- Redirect to 0x100 with 2 requests outstanding: both late responses discarded; next delivered o_InstrPc = 0x100 with the data returned for address 0x100.
- Redirect coinciding with RValid and Gnt in the same cycle: the RValid word is discarded, the granted request is dropped, and the FIFO is empty on the next cycle.
- Grant stall (Gnt=0 for 5 cycles): o_IMemAddr held at 0x8 stable, then 0x8 granted once; the wrap case with FetchPc=0xFFFF_FFFC continues at 0x0.
- With FETCH_MISALIGN_CHECK_EN: redirect to 0x102 gives o_FetchFault=1 and no requests; a following redirect to 0x200 clears the fault and fetch resumes at 0x200.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage of the SOIN-RV core.
// Issues in-order word reads to instruction memory and buffers the returned
// words in a prefetch FIFO. It presents {PC, instruction} to decode over a
// valid/ready handshake. A redirect flushes the FIFO and discards any responses
// still in flight.
//
// Ports:
//   i_Clk, i_Rst               clock, synchronous active-high reset
//   o_IMemReq/o_IMemAddr       read request and word-aligned address
//   i_IMemGnt                  request accepted this cycle
//   i_IMemRValid/i_IMemRData   in-order read response, at most one per cycle
//   i_Redirect/i_RedirectPc    redirect from branch/jump resolution
//   o_InstrValid/o_Instruction/o_InstrPc/i_InstrReady   decode handshake
//   o_FetchFault               misaligned redirect fault
//
// Optional feature: define FETCH_MISALIGN_CHECK_EN to enable the FAULT state.
// In that build a misaligned redirect target raises o_FetchFault and stops
// fetching. Without the macro, the low two bits of the redirect target are
// ignored and o_FetchFault is tied 0.
module instr_fetch_unit #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  output logic        o_IMemReq,
  output logic [31:0] o_IMemAddr,
  input  logic        i_IMemGnt,
  input  logic        i_IMemRValid,
  input  logic [31:0] i_IMemRData,
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectPc,
  output logic        o_InstrValid,
  output logic [31:0] o_Instruction,
  output logic [31:0] o_InstrPc,
  input  logic        i_InstrReady,
  output logic        o_FetchFault
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  localparam logic [0:0] ST_FETCH = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [0:0] ST_FAULT = 1'b1;
`endif

  logic [0:0]    state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n;
  logic [31:0]   resp_pc, resp_pc_n;
  logic [CW-1:0] outst, outst_n;
  logic [CW-1:0] drop_cnt, drop_n;
  logic [CW-1:0] count, count_n;
  logic [AW-1:0] rd_ptr, rd_ptr_n;
  logic [AW-1:0] wr_ptr, wr_ptr_n;
  logic          req_q, req_n;
  logic          valid_q, valid_n;
  logic [63:0]   mem [FIFO_DEPTH];
  logic [63:0]   head;
  logic          gnt_acc, rv_acc, push, pop;
  logic [31:0]   tgt;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic          misalign;
  logic          fault_q, fault_n;
`endif

  // Next-state logic: redirect wins over all normal fetch/response/pop updates.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    resp_pc_n  = resp_pc;
    drop_n     = drop_cnt;
    count_n    = count;
    rd_ptr_n   = rd_ptr;
    wr_ptr_n   = wr_ptr;
    push       = 1'b0;
    gnt_acc    = req_q & i_IMemGnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    rv_acc     = i_IMemRValid & (outst != '0);
    pop        = valid_q & i_InstrReady;
    outst_n    = outst + CW'(gnt_acc) - CW'(rv_acc);
`ifdef FETCH_MISALIGN_CHECK_EN
    tgt      = i_RedirectPc;
    misalign = (tgt[1:0] != 2'b00);
`else
    tgt      = i_RedirectPc & 32'hFFFF_FFFC;
`endif

    if (i_Redirect) begin
      // Every response still owed after this cycle belongs to the old path.
      count_n    = '0;
      rd_ptr_n   = '0;
      wr_ptr_n   = '0;
      fetch_pc_n = tgt;
      resp_pc_n  = tgt;
      drop_n     = outst_n;
`ifdef FETCH_MISALIGN_CHECK_EN
      state_n    = misalign ? ST_FAULT : ST_FETCH;
`endif
    end else begin
      if (gnt_acc) fetch_pc_n = fetch_pc + 32'd4;
      if (rv_acc) begin
        if (drop_cnt != '0) begin
          drop_n = drop_cnt - CW'(1);
        end else begin
          push      = 1'b1;
          resp_pc_n = resp_pc + 32'd4;
        end
      end
      if (push) wr_ptr_n = wr_ptr + AW'(1);
      if (pop)  rd_ptr_n = rd_ptr + AW'(1);
      count_n = count + CW'(push) - CW'(pop);
    end

    // Credit rule: buffered words plus owed responses never exceed the FIFO.
    req_n   = (state_n == ST_FETCH) &&
              ((SW'(count_n) + SW'(outst_n)) < SW'(FIFO_DEPTH));
    valid_n = (count_n != '0);
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_n = (state_n == ST_FAULT);
`endif
  end

  // State and FIFO storage registers.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state    <= ST_FETCH;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      outst    <= '0;
      drop_cnt <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      resp_pc  <= resp_pc_n;
      outst    <= outst_n;
      drop_cnt <= drop_n;
      count    <= count_n;
      rd_ptr   <= rd_ptr_n;
      wr_ptr   <= wr_ptr_n;
      req_q    <= req_n;
      valid_q  <= valid_n;
      if (push) mem[wr_ptr] <= {resp_pc, i_IMemRData};
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q  <= fault_n;
`endif
    end
  end

  assign head          = mem[rd_ptr];
  assign o_IMemReq     = req_q;
  assign o_IMemAddr    = fetch_pc;
  assign o_InstrValid  = valid_q;
  assign o_InstrPc     = head[63:32];
  assign o_Instruction = head[31:0];
`ifdef FETCH_MISALIGN_CHECK_EN
  assign o_FetchFault  = fault_q;
`else
  assign o_FetchFault  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized bench for instr_fetch_unit.
// The reference model tracks the next PC decode must see and the next address
// memory must be asked for. It keeps a queue of granted addresses as the memory
// model. Memory returns a hash of the address, so every delivered
// {PC, instruction} pair can be checked on its own.
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic        o_IMemReq;
  logic [31:0] o_IMemAddr;
  logic        i_IMemGnt = 1'b0;
  logic        i_IMemRValid = 1'b0;
  logic [31:0] i_IMemRData = '0;
  logic        i_Redirect = 1'b0;
  logic [31:0] i_RedirectPc = '0;
  logic        o_InstrValid;
  logic [31:0] o_Instruction;
  logic [31:0] o_InstrPc;
  logic        i_InstrReady = 1'b0;
  logic        o_FetchFault;

  instr_fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .i_Clk(clk), .i_Rst(i_Rst),
    .o_IMemReq(o_IMemReq), .o_IMemAddr(o_IMemAddr), .i_IMemGnt(i_IMemGnt),
    .i_IMemRValid(i_IMemRValid), .i_IMemRData(i_IMemRData),
    .i_Redirect(i_Redirect), .i_RedirectPc(i_RedirectPc),
    .o_InstrValid(o_InstrValid), .o_Instruction(o_Instruction),
    .o_InstrPc(o_InstrPc), .i_InstrReady(i_InstrReady),
    .o_FetchFault(o_FetchFault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [31:0] exp_pc, exp_fetch;
  logic [31:0] mem_q[$];
  bit          exp_fault;
  int          n_deliv, n_gnt;
  logic [31:0] last_pc, last_gnt_addr;
  bit          prev_req, prev_gnt, prev_redir;
  logic [31:0] prev_addr;
  bit          seen_valid;
  int          p_gnt, p_rv, p_rdy, p_redir;
  int          redir_arm;
  logic [31:0] redir_tgt;
  bit          redir_fired;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit roll(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  // One clock cycle: check outputs at the falling edge, drive inputs for the
  // next rising edge, then advance the model by the events that edge commits.
  task automatic cycle();
    bit g, rv, rd, rdir;
    logic [31:0] tgt;
    @(negedge clk);
    seen_valid = o_InstrValid;
    check("fault", 32'(o_FetchFault), 32'(exp_fault));
    if (exp_fault) begin
      check("req_in_fault", 32'(o_IMemReq), 32'd0);
      check("valid_in_fault", 32'(o_InstrValid), 32'd0);
    end
    if (prev_req && !prev_gnt && !prev_redir) begin
      check("req_hold", 32'(o_IMemReq), 32'd1);
      check("addr_hold", o_IMemAddr, prev_addr);
    end
    if (o_IMemReq) check("credit", 32'(mem_q.size() < int'(DEPTH)), 32'd1);

    g  = roll(p_gnt);
    rv = (mem_q.size() != 0) && roll(p_rv);
    rd = roll(p_rdy);
    rdir = 1'b0;
    tgt  = $urandom;
    if (redir_arm == 1) begin
      rdir = 1'b1; tgt = redir_tgt; redir_arm = 0; redir_fired = 1'b1;
    end else if (redir_arm == 2 && o_IMemReq && g && rv) begin
      rdir = 1'b1; tgt = redir_tgt; redir_arm = 0; redir_fired = 1'b1;
    end else if (redir_arm == 0 && roll(p_redir)) begin
      rdir = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      tgt = tgt & 32'hFFFF_FFFC;
`endif
    end
    i_IMemGnt    = g;
    i_IMemRValid = rv;
    i_IMemRData  = rv ? mem_data(mem_q[0]) : $urandom;
    i_InstrReady = rd;
    i_Redirect   = rdir;
    i_RedirectPc = tgt;

    if (o_InstrValid && rd) begin
      check("instr_pc", o_InstrPc, exp_pc);
      check("instr_data", o_Instruction, mem_data(exp_pc));
      exp_pc  = exp_pc + 32'd4;
      last_pc = o_InstrPc;
      n_deliv++;
    end
    if (o_IMemReq && g) begin
      check("gnt_addr", o_IMemAddr, exp_fetch);
      mem_q.push_back(o_IMemAddr);
      exp_fetch     = exp_fetch + 32'd4;
      last_gnt_addr = o_IMemAddr;
      n_gnt++;
    end
    if (rv) void'(mem_q.pop_front());
    if (rdir) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      exp_fault = (tgt[1:0] != 2'b00);
`endif
      exp_pc    = tgt & 32'hFFFF_FFFC;
      exp_fetch = tgt & 32'hFFFF_FFFC;
    end
    prev_req   = o_IMemReq;
    prev_gnt   = g;
    prev_addr  = o_IMemAddr;
    prev_redir = rdir;
  endtask

  // Reset for one edge; optionally drive a stray response right after release.
  task automatic do_reset(input bit stray);
    @(negedge clk);
    i_Rst = 1'b1;
    i_IMemGnt = 1'b0; i_IMemRValid = 1'b0; i_Redirect = 1'b0; i_InstrReady = 1'b0;
    @(negedge clk);
    check("rst_req", 32'(o_IMemReq), 32'd0);
    check("rst_valid", 32'(o_InstrValid), 32'd0);
    check("rst_fault", 32'(o_FetchFault), 32'd0);
    check("rst_instr", o_Instruction, 32'd0);
    check("rst_pc", o_InstrPc, 32'd0);
    mem_q.delete();
    i_Rst        = 1'b0;
    i_IMemRValid = stray;
    i_IMemRData  = 32'hDEAD_BEEF;
    exp_pc    = RST_PC;
    exp_fetch = RST_PC;
    exp_fault = 1'b0;
    prev_req  = 1'b0;
    prev_redir = 1'b1;
    redir_arm = 0;
  endtask

  task automatic set_probs(input int g, input int rv, input int rd, input int rdir);
    p_gnt = g; p_rv = rv; p_rdy = rd; p_redir = rdir;
  endtask

  initial begin
    int first, d0, g0;
    n_deliv = 0; n_gnt = 0; redir_arm = 0; last_pc = '0; last_gnt_addr = '0;

    // Zero-wait memory, decode always ready
    set_probs(100, 100, 100, 0);
    do_reset(1'b0);
    first = -1;
    d0 = n_deliv;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (first < 0 && seen_valid) first = k;
    end
    check("first_valid_cycle", 32'(first), 32'd3);
    check("zero_wait_throughput", 32'((n_deliv - d0) >= 10), 32'd1);

    // Backpressure: decode stalled for 10 cycles
    set_probs(100, 100, 0, 0);
    do_reset(1'b1);
    g0 = n_gnt;
    repeat (10) cycle();
    check("bp_grants", 32'(n_gnt - g0), 32'd2);
    check("bp_req_low", 32'(o_IMemReq), 32'd0);
    p_rdy = 100;
    d0 = n_deliv;
    repeat (4) cycle();
    check("bp_drain", 32'((n_deliv - d0) >= 2), 32'd1);

    // Redirect to 0x100 with two requests outstanding
    set_probs(100, 0, 100, 0);
    do_reset(1'b0);
    repeat (3) cycle();
    check("two_outstanding", 32'(mem_q.size()), 32'd2);
    redir_arm = 1; redir_tgt = 32'h0000_0100;
    cycle();
    p_rv = 100;
    d0 = n_deliv;
    for (int k = 0; k < 20 && n_deliv == d0; k++) cycle();
    check("redir_deliver", 32'(n_deliv > d0), 32'd1);
    check("redir_first_pc", last_pc, 32'h0000_0100);

    // Redirect in the same cycle as a grant and a response
    set_probs(100, 100, 100, 0);
    do_reset(1'b0);
    repeat (4) cycle();
    redir_arm = 2; redir_tgt = 32'h0000_0400; redir_fired = 1'b0;
    for (int k = 0; k < 10 && !redir_fired; k++) cycle();
    check("redir_fire", 32'(redir_fired), 32'd1);
    cycle();
    check("redir_flush", 32'(seen_valid), 32'd0);
    d0 = n_deliv;
    for (int k = 0; k < 20 && n_deliv == d0; k++) cycle();
    check("redir2_first_pc", last_pc, 32'h0000_0400);

    // Grant stall at 0x8, then wrap from 0xFFFF_FFFC
    set_probs(100, 100, 100, 0);
    do_reset(1'b0);
    repeat (2) cycle();
    p_gnt = 0;
    cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("stall_req", 32'(o_IMemReq), 32'd1);
      check("stall_addr", o_IMemAddr, 32'h0000_0008);
    end
    p_gnt = 100;
    g0 = n_gnt;
    cycle();
    check("stall_gnt_count", 32'(n_gnt - g0), 32'd1);
    check("stall_gnt_addr", last_gnt_addr, 32'h0000_0008);
    redir_arm = 1; redir_tgt = 32'hFFFF_FFFC;
    cycle();
    d0 = n_deliv;
    for (int k = 0; k < 30 && n_deliv < d0 + 2; k++) cycle();
    check("wrap_pc", last_pc, 32'h0000_0000);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect enters FAULT; an aligned redirect recovers
    set_probs(100, 100, 100, 0);
    do_reset(1'b0);
    repeat (3) cycle();
    redir_arm = 1; redir_tgt = 32'h0000_0102;
    cycle();
    g0 = n_gnt;
    repeat (5) cycle();
    check("fault_set", 32'(o_FetchFault), 32'd1);
    check("fault_no_gnt", 32'(n_gnt - g0), 32'd0);
    redir_arm = 1; redir_tgt = 32'h0000_0200;
    cycle();
    d0 = n_deliv;
    for (int k = 0; k < 20 && n_deliv == d0; k++) cycle();
    check("fault_clear", 32'(o_FetchFault), 32'd0);
    check("fault_resume_pc", last_pc, 32'h0000_0200);
`endif

    // Random traffic with redirects and one mid-transaction reset
    do_reset(1'b0);
    d0 = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0)
        set_probs(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                  int'($urandom_range(100, 20)), 3);
      if (i == 1500) do_reset(1'b1);
      cycle();
    end
    check("random_progress", 32'((n_deliv - d0) > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
